// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop handshake plus external single-port RAM signals for ram_fifo_ctrl.
// master = the FIFO controller, slave = the producer/consumer/RAM environment.
interface ram_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ram_cs;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        input  wr_valid, wr_data, rd_ready, ram_dout,
        output wr_ready, rd_valid, rd_data, ram_cs, ram_we, ram_addr, ram_din
    );

    modport slave (
        output wr_valid, wr_data, rd_ready, ram_dout,
        input  wr_ready, rd_valid, rd_data, ram_cs, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller keeping its storage in an external single-port async-read RAM,
// with a registered output word. Define FIFO_LEVEL_EN to add the 'level' output.
module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ram_fifo_ctrl_if.master        io_bus
`ifdef FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]    level
`endif
);
    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

    state_t                r_st;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_mem_cnt;
    logic                  r_ram_cs;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_din;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic w_full;
    logic w_rd_need;
    logic w_wr_ready;
    logic w_push;
    logic w_pop;

    // mem_cnt never exceeds DEPTH = 2**ADDR_WIDTH, so its MSB alone means full.
    assign w_full     = r_mem_cnt[ADDR_WIDTH];
    assign w_rd_need  = (r_mem_cnt != '0) && (r_st != ST_RD) && (!r_rd_valid || io_bus.rd_ready);
    assign w_wr_ready = !w_rd_need && !w_full;
    assign w_push     = io_bus.wr_valid && w_wr_ready;
    assign w_pop      = r_rd_valid && io_bus.rd_ready;

    // NOTE: every r_ register is assigned non-blocking so all of them update from
    // the same pre-edge values; blocking here would let later lines see new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st       <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_ram_cs   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (r_st == ST_RD) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= io_bus.ram_dout;
            end else if (w_pop) begin
                r_rd_valid <= 1'b0;
            end

            if (w_rd_need) begin
                r_st       <= ST_RD;
                r_ram_cs   <= 1'b1;
                r_ram_we   <= 1'b0;
                r_ram_addr <= r_rd_ptr;
                r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
                r_mem_cnt  <= r_mem_cnt - (ADDR_WIDTH+1)'(1);
            end else if (w_push) begin
                r_st       <= ST_WR;
                r_ram_cs   <= 1'b1;
                r_ram_we   <= 1'b1;
                r_ram_addr <= r_wr_ptr;
                r_ram_din  <= io_bus.wr_data;
                r_wr_ptr   <= r_wr_ptr + ADDR_WIDTH'(1);
                r_mem_cnt  <= r_mem_cnt + (ADDR_WIDTH+1)'(1);
            end else begin
                r_st     <= ST_IDLE;
                r_ram_cs <= 1'b0;
                r_ram_we <= 1'b0;
            end
        end
    end

    assign io_bus.wr_ready = w_wr_ready;
    assign io_bus.rd_valid = r_rd_valid;
    assign io_bus.rd_data  = r_rd_data;
    assign io_bus.ram_cs   = r_ram_cs;
    assign io_bus.ram_we   = r_ram_we;
    assign io_bus.ram_addr = r_ram_addr;
    assign io_bus.ram_din  = r_ram_din;

`ifdef FIFO_LEVEL_EN
    // Reads only move a word between RAM, the RD stage and the output register,
    // so mem_cnt + (st==RD) + rd_valid changes only on push and pop.
    logic [ADDR_WIDTH:0] r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (w_push && !w_pop) begin
            r_level <= r_level + (ADDR_WIDTH+1)'(1);
        end else if (w_pop && !w_push) begin
            r_level <= r_level - (ADDR_WIDTH+1)'(1);
        end
    end

    assign level = r_level;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural async-read RAM.
// Builds with or without FIFO_LEVEL_EN.
module tb_ram_fifo_ctrl;
    logic clk;
    logic rst_n;
`ifdef FIFO_LEVEL_EN
    logic [8:0] level;
`endif

    ram_fifo_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

    ram_fifo_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
`ifdef FIFO_LEVEL_EN
        ,
        .level  (level)
`endif
    );

    // External RAM: asynchronous read, write on the rising edge while selected.
    logic [15:0] ram_mem [256];
    assign bus.ram_dout = ram_mem[bus.ram_addr];
    always @(posedge clk) if (bus.ram_cs && bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] sb [$];
    logic        mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.wr_ready;
            tick();
            n++;
        end
        bus.wr_valid = 1'b0;
        if (acc) sb.push_back(d);
        else check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.rd_ready = 1'b1;
        while (sb.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        check("drain_done", sb.size(), 32'd0);
        tick();
        tick();
        bus.rd_ready = 1'b0;
    endtask

    // Monitor: RAM write/read addresses follow push/pop order, popped words match the scoreboard.
    initial begin
        logic       wr_pend;
        logic [7:0] exp_waddr;
        logic [7:0] exp_raddr;
        logic [15:0] exp_din;
        logic [15:0] exp_word;
        wr_pend   = 1'b0;
        exp_waddr = 8'd0;
        exp_raddr = 8'd0;
        exp_din   = 16'd0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("we_without_cs", {31'd0, bus.ram_we && !bus.ram_cs}, 32'd0);
                check("write_issue", {31'd0, bus.ram_we}, {31'd0, wr_pend});
                if (wr_pend) begin
                    check("write_addr", {24'd0, bus.ram_addr}, {24'd0, exp_waddr});
                    check("write_din", {16'd0, bus.ram_din}, {16'd0, exp_din});
                    exp_waddr = exp_waddr + 8'd1;
                end
                if (bus.ram_cs && !bus.ram_we) begin
                    check("read_addr", {24'd0, bus.ram_addr}, {24'd0, exp_raddr});
                    exp_raddr = exp_raddr + 8'd1;
                end
                wr_pend = bus.wr_valid && bus.wr_ready;
                exp_din = bus.wr_data;
                if (bus.rd_valid && bus.rd_ready) begin
                    if (sb.size() == 0) begin
                        check("pop_underflow", {16'd0, bus.rd_data}, 32'hFFFF_FFFF);
                    end else begin
                        exp_word = sb.pop_front();
                        check("pop_data", {16'd0, bus.rd_data}, {16'd0, exp_word});
                    end
                end
            end
        end
    end

    initial begin
        int          idx;
        int          n;
        logic        acc;
        logic [7:0]  a;
        logic [15:0] old;

        rst_n        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 16'd0;
        bus.rd_ready = 1'b0;

        // Reset values, before any clock edge.
        #3;
        check("rst_cs", {31'd0, bus.ram_cs}, 32'd0);
        check("rst_we", {31'd0, bus.ram_we}, 32'd0);
        check("rst_addr", {24'd0, bus.ram_addr}, 32'd0);
        check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("rst_rd_data", {16'd0, bus.rd_data}, 32'd0);
        check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
`ifdef FIFO_LEVEL_EN
        check("rst_level", {23'd0, level}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Three words with rd_ready low; first word reaches rd_data two edges after its write issue.
        push(16'hAAAA);
        @(negedge clk);
        check("rd_priority_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
        tick();
        check("lat_rd_valid_e2", {31'd0, bus.rd_valid}, 32'd0);
        tick();
        check("lat_rd_valid_e3", {31'd0, bus.rd_valid}, 32'd1);
        check("lat_rd_data_e3", {16'd0, bus.rd_data}, 32'h0000_AAAA);
        push(16'h5555);
        push(16'hF00D);
        repeat (3) tick();
        check("hold_rd_data", {16'd0, bus.rd_data}, 32'h0000_AAAA);
        drain();

        // Contention: output register full, 3 words in RAM, pop and push requested together.
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        push(16'h4444);
        repeat (3) tick();
`ifdef FIFO_LEVEL_EN
        check("contend_level", {23'd0, level}, 32'd4);
`endif
        bus.rd_ready = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'hC0DE;
        @(negedge clk);
        check("contend_wr_ready_0", {31'd0, bus.wr_ready}, 32'd0);
        tick();
        check("contend_rd_issue", {30'd0, bus.ram_cs, bus.ram_we}, 32'd2);
        bus.rd_ready = 1'b0;
        @(negedge clk);
        check("contend_wr_ready_1", {31'd0, bus.wr_ready}, 32'd1);
        tick();
        check("contend_wr_issue", {30'd0, bus.ram_cs, bus.ram_we}, 32'd3);
        sb.push_back(16'hC0DE);
        bus.wr_valid = 1'b0;
        drain();

        // Fill: DEPTH words in RAM plus one in the output register.
        for (int i = 0; i < 257; i++) push(16'(i));
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'hDEAD;
        repeat (5) begin
            @(negedge clk);
            check("full_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
            tick();
        end
        bus.wr_valid = 1'b0;
`ifdef FIFO_LEVEL_EN
        check("full_level", {23'd0, level}, 32'd257);
`endif
        drain();

        // Empty: popping with nothing stored must not touch the RAM.
        bus.rd_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("empty_cs", {31'd0, bus.ram_cs}, 32'd0);
            check("empty_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
            tick();
        end
        bus.rd_ready = 1'b0;

        // Wrap: 600 words with random push/pop pacing.
        idx = 0;
        n   = 0;
        while (idx < 600 && n < 6000) begin
            bus.wr_valid = ($urandom_range(0, 3) != 0);
            bus.wr_data  = 16'(16'h9000 + idx);
            bus.rd_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            acc = bus.wr_valid && bus.wr_ready;
            tick();
            n++;
            if (acc) begin
                sb.push_back(bus.wr_data);
                idx++;
            end
        end
        bus.wr_valid = 1'b0;
        check("wrap_all_pushed", idx, 32'd600);
        drain();

        // Asynchronous reset with a RAM write in flight.
        push(16'h1234);
        mon_en = 1'b0;
        check("rst_mid_write_active", {31'd0, bus.ram_we}, 32'd1);
        a   = bus.ram_addr;
        old = ram_mem[a];
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_cs", {31'd0, bus.ram_cs}, 32'd0);
        check("rst_mid_we", {31'd0, bus.ram_we}, 32'd0);
        check("rst_mid_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("rst_mid_rd_data", {16'd0, bus.rd_data}, 32'd0);
        check("rst_mid_addr", {24'd0, bus.ram_addr}, 32'd0);
        tick();
        check("rst_no_ram_write", {16'd0, ram_mem[a]}, {16'd0, old});
`ifdef FIFO_LEVEL_EN
        check("rst_mid_level", {23'd0, level}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
